// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side controllers.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        ACKWAIT = 2'd2,
        DRAIN   = 2'd3
    } arb_state_t;

    localparam int BYTE_W          = 8;
    localparam int ACK_TIMEOUT_DEF = 8;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority picker: first eligible index at or above ptr_i, wrapping.
module uart_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic found;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!found && eligible_i[j]) begin
                found         = 1'b1;
                grant_oh_o[j] = 1'b1;
                grant_idx_o   = IDX_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NREQ byte sources, with per-requester
// frame lock and a sticky flag for a transmitter that never acknowledges a write.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    localparam int IDX_W       = $clog2(NREQ)
) (
    input  logic                     mclkx16,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BYTE_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_write,
    output logic [BYTE_W-1:0]        tx_data,
    input  logic                     tx_txrdy,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy,
    output logic                     locked,
    output logic                     err_nack,
    input  logic                     err_clear,
    output arb_state_t               dbg_state
);

    localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREQ - 1);

    arb_state_t          state_q, state_d;
    logic                rdy_meta_q, rdy_s_q;
    logic                tx_write_q, tx_write_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NREQ-1:0]     lock_mask, eligible, pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    // Handshake: a byte moves when req_valid[i] && req_ready[i] on a rising mclkx16;
    // req_ready is one-hot, lasts one cycle and only ever appears in IDLE.
    assign lock_mask = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_q;
    assign eligible  = locked_q ? (req_valid & lock_mask) : req_valid;

    uart_rr_arbiter #(.N(NREQ)) u_pick (
        .eligible_i  (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .any_o       (pick_any)
    );

    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
            tx_write_q <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rdy_meta_q <= tx_txrdy;
            rdy_s_q    <= rdy_meta_q;
            tx_write_q <= tx_write_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        if (err_clear) err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdy_s_q && pick_any) begin
                    req_ready  = pick_oh;
                    tx_data_d  = req_data[pick_idx*BYTE_W +: BYTE_W];
                    grant_id_d = pick_idx;
                    locked_d   = !req_last[pick_idx];
                    if (req_last[pick_idx])
                        rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                    tx_write_d = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = '0;
                state_d = ACKWAIT;
            end
            ACKWAIT: begin
                if (!rdy_s_q) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // A silent transmitter must not wedge the bus; the byte is written off.
                    if (cnt_d == CNT_MAX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (rdy_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_write  = tx_write_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);
    assign locked    = locked_q;
    assign err_nack  = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter with a queue-based reference of the grant order.
module tb_uart_tx_arbiter;
    import uart_ctrl_pkg::*;

    localparam int NREQ   = 4;
    localparam int ACK_TO = 8;

    logic              mclkx16;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_last, req_ready;
    logic [NREQ*8-1:0] req_data;
    logic              tx_write, tx_txrdy, busy, locked, err_nack, err_clear;
    logic [7:0]        tx_data;
    logic [1:0]        grant_id;
    arb_state_t        dbg_state;

    uart_tx_arbiter #(.NREQ(NREQ), .ACK_TIMEOUT(ACK_TO)) dut (
        .mclkx16(mclkx16), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_write(tx_write), .tx_data(tx_data),
        .tx_txrdy(tx_txrdy), .grant_id(grant_id), .busy(busy), .locked(locked),
        .err_nack(err_nack), .err_clear(err_clear), .dbg_state(dbg_state)
    );

    // sources hold {last, data}; expected/accepted entries are {idx, last, data}
    logic [8:0]  src_q [NREQ][$];
    logic [10:0] exp_q[$];
    logic [10:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [7:0]  wr_q[$];
    int          wr_cyc_q[$];
    logic        wr_lock_q[$];

    int m_ptr = 0, m_gid = 0;
    bit m_lock = 0;
    int cyc = 0;
    int n_checks = 0, n_fail = 0;
    int ready_cnt = 0, mon_multi = 0, mon_ready_busy = 0, mon_data_bad = 0;
    int tx_mode = 0;     // 0: level from tx_manual, 1: acknowledging transmitter, 2: ignores writes
    bit tx_manual = 0;
    int tx_load = 4;
    logic [NREQ-1:0] take;

    initial begin
        mclkx16 = 0;
        forever #5 mclkx16 = ~mclkx16;
    end

    always @(posedge mclkx16) cyc <= cyc + 1;

    // requester drivers and output monitor
    initial begin
        logic [7:0] prev_data;
        bit prev_acc, prev_rst;
        req_valid = '0; req_last = '0; req_data = '0; take = '0;
        prev_data = 8'h00; prev_acc = 0; prev_rst = 1;
        forever begin
            @(negedge mclkx16);
            for (int i = 0; i < NREQ; i++) begin
                if (take[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                take[i] = 1'b0;
                if (src_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_last[i]  = src_q[i][0][8];
                    req_data[i*8 +: 8] = src_q[i][0][7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                end
            end
            #1;
            if (req_ready != '0) ready_cnt++;
            if ($countones(req_ready) > 1) mon_multi++;
            if (req_ready != '0 && busy) mon_ready_busy++;
            if (!reset && !prev_rst && !prev_acc && tx_data !== prev_data) mon_data_bad++;
            prev_acc = 0;
            if (!reset) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        take[i] = 1'b1;
                        acc_q.push_back({2'(i), req_last[i], req_data[i*8 +: 8]});
                        acc_cyc_q.push_back(cyc);
                        prev_acc = 1;
                    end
                end
                if (tx_write) begin
                    wr_q.push_back(tx_data);
                    wr_cyc_q.push_back(cyc);
                    wr_lock_q.push_back(locked);
                end
            end
            prev_data = tx_data;
            prev_rst  = reset;
        end
    end

    // transmitter model: drops txrdy the cycle after a write, raises it tx_load+1 cycles later
    initial begin
        bit drop_next, dropping;
        int load;
        tx_txrdy = 0; drop_next = 0; dropping = 0; load = 0;
        forever begin
            @(negedge mclkx16);
            #2;
            if (tx_mode == 0) begin
                tx_txrdy = tx_manual; drop_next = 0; dropping = 0;
            end else if (tx_mode == 2) begin
                tx_txrdy = 1; drop_next = 0; dropping = 0;
            end else begin
                if (drop_next) begin
                    tx_txrdy = 0; load = tx_load; dropping = 1; drop_next = 0;
                end else if (dropping) begin
                    if (load == 0) begin dropping = 0; tx_txrdy = 1; end
                    else load--;
                end else begin
                    tx_txrdy = 1;
                end
                if (tx_write) drop_next = 1;
            end
        end
    end

    // grant order from the rules: lock holder first, else first non-empty source at/after ptr
    task automatic model_run();
        logic [8:0] m_q [NREQ][$];
        logic [8:0] item;
        for (int i = 0; i < NREQ; i++) m_q[i] = src_q[i];
        forever begin
            int w;
            w = -1;
            if (m_lock) begin
                if (m_q[m_gid].size() > 0) w = m_gid;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && m_q[(m_ptr + k) % NREQ].size() > 0) w = (m_ptr + k) % NREQ;
            end
            if (w < 0) break;
            item = m_q[w].pop_front();
            exp_q.push_back({2'(w), item});
            m_gid  = w;
            m_lock = !item[8];
            if (item[8]) m_ptr = (w + 1) % NREQ;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete(); acc_q.delete(); acc_cyc_q.delete();
        wr_q.delete(); wr_cyc_q.delete(); wr_lock_q.delete();
        m_ptr = 0; m_gid = 0; m_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge mclkx16);
        reset = 1;
        repeat (3) @(negedge mclkx16);
        flush();
        reset = 0;
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (acc_q.size() < n && t < budget) begin
            @(negedge mclkx16);
            t++;
        end
        repeat (2) @(negedge mclkx16);
        #3;
        ok = (acc_q.size() >= n) && (wr_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int t;
        t = 0;
        @(negedge mclkx16); #1;
        while (busy !== 1'b0 && t < budget) begin
            @(negedge mclkx16); #1;
            t++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        bit ok;
        int r;
        logic [10:0] a, e;
        tx_mode = 0; tx_manual = 0; tx_load = 4; err_clear = 0;
        reset = 1;
        repeat (3) @(negedge mclkx16);
        #1;
        n_checks++; if (tx_write !== 1'b0) begin n_fail++; $display("FAIL rst_tx_write: got %b expected 0", tx_write); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", locked); end
        n_checks++; if (err_nack !== 1'b0) begin n_fail++; $display("FAIL rst_err_nack: got %b expected 0", err_nack); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected IDLE", dbg_state); end
        flush();
        @(negedge mclkx16);
        reset = 0;
        src_q[1].push_back({1'b1, 8'h3C});
        model_run();
        repeat (10) @(negedge mclkx16);
        #3;
        n_checks++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL gate_no_grant: got %0d grants expected 0", acc_q.size()); end
        @(negedge mclkx16);
        r = cyc;
        tx_mode = 1;
        wait_acc(1, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL gate_grant: no grant within budget");
        end else begin
            a = acc_q.pop_front(); e = exp_q.pop_front();
            if (a !== e) begin n_fail++; $display("FAIL gate_grant: got %h expected %h", a, e); end
            n_checks++;
            if (acc_cyc_q[0] !== r + 2) begin n_fail++; $display("FAIL gate_latency: got cycle %0d expected %0d", acc_cyc_q[0], r + 2); end
            void'(acc_cyc_q.pop_front()); void'(wr_q.pop_front()); void'(wr_cyc_q.pop_front()); void'(wr_lock_q.pop_front());
        end
        wait_idle(100, ok);
    endtask

    task automatic test_single();
        bit ok;
        int r0, ac, wc, idle_c;
        logic [10:0] a, e;
        logic [7:0] wd;
        tx_mode = 1; tx_load = 39;
        r0 = ready_cnt;
        src_q[2].push_back({1'b1, 8'hA5});
        model_run();
        wait_acc(1, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL single_grant: no grant/write within budget");
        end else begin
            a = acc_q.pop_front(); e = exp_q.pop_front(); ac = acc_cyc_q.pop_front();
            wd = wr_q.pop_front(); wc = wr_cyc_q.pop_front(); void'(wr_lock_q.pop_front());
            if (a !== e || a !== {2'd2, 1'b1, 8'hA5}) begin n_fail++; $display("FAIL single_grant: got %h expected %h", a, e); end
            n_checks++; if (wc !== ac + 1) begin n_fail++; $display("FAIL single_write_cycle: got %0d expected %0d", wc, ac + 1); end
            n_checks++; if (wd !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %h expected a5", wd); end
            n_checks++; if (ready_cnt - r0 !== 1) begin n_fail++; $display("FAIL single_ready_cycles: got %0d expected 1", ready_cnt - r0); end
            wait_idle(100, ok);
            idle_c = cyc;
            n_checks++; if (!ok || idle_c - wc < 40) begin n_fail++; $display("FAIL single_drain: busy low at %0d, write at %0d", idle_c, wc); end
            n_checks++; if (grant_id !== 2'd2 || locked !== 1'b0) begin n_fail++; $display("FAIL single_status: grant %0d locked %b expected 2/0", grant_id, locked); end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int r0, ac, wc, prev;
        logic [10:0] a, e;
        logic [7:0] wd;
        logic wl;
        int rr_ord[5] = '{0, 1, 2, 3, 0};
        tx_mode = 1; tx_load = 1;
        do_reset();
        r0 = ready_cnt;
        src_q[0].push_back({1'b1, 8'($urandom)});
        src_q[0].push_back({1'b1, 8'($urandom)});
        for (int i = 1; i < NREQ; i++) src_q[i].push_back({1'b1, 8'($urandom)});
        model_run();
        wait_acc(5, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rr_count: got %0d grants expected 5", acc_q.size());
        end else begin
            prev = -100;
            for (int k = 0; k < 5; k++) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); ac = acc_cyc_q.pop_front();
                wd = wr_q.pop_front(); wc = wr_cyc_q.pop_front(); wl = wr_lock_q.pop_front();
                n_checks++; if (a !== e || int'(a[10:9]) != rr_ord[k]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %h expected %h", k, a, e); end
                n_checks++; if (wc !== ac + 1 || wd !== e[7:0]) begin n_fail++; $display("FAIL rr_write[%0d]: got %h@%0d expected %h@%0d", k, wd, wc, e[7:0], ac + 1); end
                n_checks++; if (ac - prev < 5) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected >=5", k, ac - prev); end
                prev = ac;
            end
        end
        n_checks++; if (ready_cnt - r0 !== 5) begin n_fail++; $display("FAIL rr_ready_cycles: got %0d expected 5", ready_cnt - r0); end
    endtask

    task automatic test_frame_lock();
        bit ok;
        int ac, wc;
        logic [10:0] a, e;
        logic [7:0] wd;
        logic wl;
        int fl_ord[5] = '{1, 1, 1, 3, 0};
        tx_mode = 1; tx_load = 3;
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h12});
        src_q[1].push_back({1'b1, 8'h13});
        src_q[0].push_back({1'b1, 8'h0A});
        src_q[3].push_back({1'b1, 8'h3A});
        model_run();
        wait_acc(5, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL lock_count: got %0d grants expected 5", acc_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); ac = acc_cyc_q.pop_front();
                wd = wr_q.pop_front(); wc = wr_cyc_q.pop_front(); wl = wr_lock_q.pop_front();
                n_checks++; if (a !== e || int'(a[10:9]) != fl_ord[k]) begin n_fail++; $display("FAIL lock_grant[%0d]: got %h expected %h", k, a, e); end
                n_checks++; if (wc !== ac + 1 || wd !== e[7:0]) begin n_fail++; $display("FAIL lock_write[%0d]: got %h@%0d expected %h@%0d", k, wd, wc, e[7:0], ac + 1); end
                n_checks++; if (wl !== !e[8]) begin n_fail++; $display("FAIL lock_flag[%0d]: got %b expected %b", k, wl, !e[8]); end
            end
        end
    endtask

    task automatic test_ack_timeout();
        bit ok, seen;
        int wc, t, er;
        logic [10:0] a, e;
        tx_mode = 2;
        src_q[2].push_back({1'b1, 8'h5E});
        model_run();
        wait_acc(1, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL ack_grant: no grant within budget");
        end else begin
            a = acc_q.pop_front(); e = exp_q.pop_front();
            if (a !== e) begin n_fail++; $display("FAIL ack_grant: got %h expected %h", a, e); end
            void'(acc_cyc_q.pop_front()); void'(wr_q.pop_front()); void'(wr_lock_q.pop_front());
            wc = wr_cyc_q.pop_front();
            t = 0;
            while (err_nack !== 1'b1 && t < 30) begin @(negedge mclkx16); #1; t++; end
            er = cyc;
            n_checks++; if (err_nack !== 1'b1 || er < wc + ACK_TO || er > wc + ACK_TO + 2) begin n_fail++; $display("FAIL ack_err_rise: err %b at %0d, write at %0d", err_nack, er, wc); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_idle: busy %b expected 0", busy); end
        end
        src_q[0].push_back({1'b1, 8'hC3});
        model_run();
        wait_acc(1, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL ack_next_grant: no grant within budget");
        end else begin
            a = acc_q.pop_front(); e = exp_q.pop_front();
            if (a !== e) begin n_fail++; $display("FAIL ack_next_grant: got %h expected %h", a, e); end
            void'(acc_cyc_q.pop_front()); void'(wr_q.pop_front()); void'(wr_cyc_q.pop_front()); void'(wr_lock_q.pop_front());
        end
        n_checks++; if (err_nack !== 1'b1) begin n_fail++; $display("FAIL ack_sticky: got %b expected 1", err_nack); end
        wait_idle(40, ok);
        @(negedge mclkx16); err_clear = 1;
        @(negedge mclkx16); err_clear = 0;
        #1;
        n_checks++; if (err_nack !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b expected 0", err_nack); end
        // clear held through a timeout: the set must still show for a cycle
        err_clear = 1;
        src_q[1].push_back({1'b1, 8'h77});
        model_run();
        seen = 0; t = 0;
        while (!seen && t < 40) begin @(negedge mclkx16); #1; t++; if (err_nack === 1'b1) seen = 1; end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL ack_set_wins: err_nack 0 expected a high cycle"); end
        @(negedge mclkx16); #1;
        n_checks++; if (err_nack !== 1'b0) begin n_fail++; $display("FAIL ack_clear_after_set: got %b expected 0", err_nack); end
        err_clear = 0;
        n_checks++;
        if (acc_q.size() < 1) begin
            n_fail++; $display("FAIL ack_third_grant: got no grant expected 1");
        end else begin
            a = acc_q.pop_front(); e = exp_q.pop_front();
            if (a !== e) begin n_fail++; $display("FAIL ack_third_grant: got %h expected %h", a, e); end
            void'(acc_cyc_q.pop_front()); void'(wr_q.pop_front()); void'(wr_cyc_q.pop_front()); void'(wr_lock_q.pop_front());
        end
        tx_mode = 1;
        wait_idle(40, ok);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int t, r, ac;
        logic [10:0] a, e;
        tx_mode = 1; tx_load = 30;
        src_q[2].push_back({1'b0, 8'h9B});
        model_run();
        wait_acc(1, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_first_grant: no grant within budget");
        end else begin
            a = acc_q.pop_front(); e = exp_q.pop_front();
            if (a !== e) begin n_fail++; $display("FAIL mid_first_grant: got %h expected %h", a, e); end
        end
        t = 0;
        while (dbg_state !== DRAIN && t < 20) begin @(negedge mclkx16); #1; t++; end
        n_checks++; if (dbg_state !== DRAIN || locked !== 1'b1) begin n_fail++; $display("FAIL mid_drain_locked: state %0d locked %b expected DRAIN/1", dbg_state, locked); end
        #2;
        reset = 1;
        #1;
        n_checks++;
        if (tx_write !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0 || grant_id !== 2'd0 ||
            busy !== 1'b0 || locked !== 1'b0 || err_nack !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: wr %b data %h rdy %b gid %0d busy %b lock %b err %b state %0d expected all zero/IDLE",
                     tx_write, tx_data, req_ready, grant_id, busy, locked, err_nack, dbg_state);
        end
        tx_mode = 0; tx_manual = 1;
        repeat (3) @(negedge mclkx16);
        flush();
        src_q[2].push_back({1'b1, 8'h9C});
        src_q[0].push_back({1'b1, 8'h01});
        model_run();
        r = cyc;
        reset = 0;
        tx_mode = 1; tx_load = 2;
        wait_acc(2, 60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_regrant: got %0d grants expected 2", acc_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                a = acc_q.pop_front(); e = exp_q.pop_front(); ac = acc_cyc_q.pop_front();
                void'(wr_q.pop_front()); void'(wr_cyc_q.pop_front()); void'(wr_lock_q.pop_front());
                n_checks++; if (a !== e) begin n_fail++; $display("FAIL mid_grant[%0d]: got %h expected %h", k, a, e); end
                if (k == 0) begin
                    n_checks++; if (ac !== r + 2) begin n_fail++; $display("FAIL mid_first_latency: got cycle %0d expected %0d", ac, r + 2); end
                end
            end
        end
        wait_idle(60, ok);
    endtask

    task automatic test_random();
        bit ok;
        int n, ac, wc, len;
        logic [10:0] a, e;
        logic [7:0] wd;
        logic wl;
        for (int round = 0; round < 4; round++) begin
            tx_mode = 1;
            tx_load = $urandom_range(0, 12);
            for (int i = 0; i < NREQ; i++) begin
                for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) src_q[i].push_back({b == len - 1, 8'($urandom)});
                end
            end
            model_run();
            n = exp_q.size();
            wait_acc(n, n * 40 + 40, ok);
            n_checks++;
            if (!ok || acc_q.size() != n) begin
                n_fail++; $display("FAIL rnd_count[%0d]: got %0d grants expected %0d", round, acc_q.size(), n);
                flush();
            end else begin
                for (int k = 0; k < n; k++) begin
                    a = acc_q.pop_front(); e = exp_q.pop_front(); ac = acc_cyc_q.pop_front();
                    wd = wr_q.pop_front(); wc = wr_cyc_q.pop_front(); wl = wr_lock_q.pop_front();
                    n_checks++; if (a !== e) begin n_fail++; $display("FAIL rnd_grant[%0d.%0d]: got %h expected %h", round, k, a, e); end
                    n_checks++; if (wc !== ac + 1 || wd !== e[7:0] || wl !== !e[8]) begin n_fail++; $display("FAIL rnd_write[%0d.%0d]: got %h@%0d lock %b expected %h@%0d lock %b", round, k, wd, wc, wl, e[7:0], ac + 1, !e[8]); end
                end
            end
            wait_idle(60, ok);
        end
    endtask

    task automatic test_monitors();
        n_checks++; if (mon_multi !== 0) begin n_fail++; $display("FAIL mon_onehot: got %0d multi-hot cycles expected 0", mon_multi); end
        n_checks++; if (mon_ready_busy !== 0) begin n_fail++; $display("FAIL mon_ready_busy: got %0d cycles expected 0", mon_ready_busy); end
        n_checks++; if (mon_data_bad !== 0) begin n_fail++; $display("FAIL mon_tx_data_hold: got %0d changes expected 0", mon_data_bad); end
    endtask

    initial begin
        reset = 1; err_clear = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_frame_lock();
        test_ack_timeout();
        test_reset_mid_frame();
        test_random();
        test_monitors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
